// File: rtl/test_sequencer.sv
// test_sequencer: run controller for the arithmetic test harness.
// Sequences harness clear, stimulus enable, pipeline drain, scoreboard freeze and result capture.
module test_sequencer #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned CLEAR_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_run_length,
    input  logic [WIDTH-1:0] i_data_ctr,
    input  logic [WIDTH-1:0] i_event_ctr,
    output logic             o_hpc_reset,
    output logic             o_hpc_enable,
    output logic             o_hpc_freeze,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted,
    output logic             o_fail,
    output logic [WIDTH-1:0] o_cycles_run,
    output logic [WIDTH-1:0] o_data_cap,
    output logic [WIDTH-1:0] o_event_cap
);

    localparam int unsigned CAPTURE_CYCLES = 2;
    localparam int unsigned MAX_CD    = (CLEAR_CYCLES > DRAIN_CYCLES) ? CLEAR_CYCLES : DRAIN_CYCLES;
    localparam int unsigned MAX_PHASE = (MAX_CD > CAPTURE_CYCLES) ? MAX_CD : CAPTURE_CYCLES;
    localparam int unsigned TW        = $clog2(MAX_PHASE);

    localparam logic [TW-1:0] CLEAR_LAST   = TW'(CLEAR_CYCLES - 1);
    localparam logic [TW-1:0] DRAIN_LAST   = TW'(DRAIN_CYCLES - 1);
    localparam logic [TW-1:0] CAPTURE_LAST = TW'(CAPTURE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state_q, state_n;
    logic [TW-1:0]     timer_q, timer_n;
    logic [WIDTH-1:0]  len_q, len_n;
    logic [WIDTH-1:0]  cycles_n, data_n, event_n;
    logic              aborted_n, fail_n;
    logic              hpc_reset_n, hpc_enable_n, hpc_freeze_n, busy_n, done_n;
    logic              abort_ok;

    // Next-state, phase timer and result bookkeeping
    always_comb begin
        state_n   = state_q;
        timer_n   = timer_q;
        len_n     = len_q;
        cycles_n  = o_cycles_run;
        data_n    = o_data_cap;
        event_n   = o_event_cap;
        aborted_n = o_aborted;
        fail_n    = o_fail;
        abort_ok  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_n   = S_CLEAR;
                    timer_n   = '0;
                    len_n     = i_run_length;
                    cycles_n  = '0;
                    data_n    = '0;
                    event_n   = '0;
                    aborted_n = 1'b0;
                    fail_n    = 1'b0;
                end
            end
            S_CLEAR: begin
                abort_ok = i_abort;
                if (timer_q == CLEAR_LAST) begin
                    timer_n = '0;
                    state_n = (len_q == '0) ? S_DRAIN : S_RUN;
                end else begin
                    timer_n = timer_q + TW'(1);
                end
            end
            S_RUN: begin
                // Count every RUN cycle, including one cut short by abort
                abort_ok = i_abort;
                cycles_n = o_cycles_run + WIDTH'(1);
                if (o_cycles_run == len_q - WIDTH'(1)) begin
                    state_n = S_DRAIN;
                    timer_n = '0;
                end
            end
            S_DRAIN: begin
                abort_ok = i_abort;
                if (timer_q == DRAIN_LAST) begin
                    timer_n = '0;
                    state_n = S_CAPTURE;
                end else begin
                    timer_n = timer_q + TW'(1);
                end
            end
            S_CAPTURE: begin
                if (timer_q == CAPTURE_LAST) begin
                    timer_n = '0;
                    state_n = S_DONE;
                    data_n  = i_data_ctr;
                    event_n = i_event_ctr;
                    fail_n  = (i_event_ctr != '0);
                end else begin
                    timer_n = timer_q + TW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
        endcase

        if (abort_ok) begin
            state_n   = S_CAPTURE;
            timer_n   = '0;
            aborted_n = 1'b1;
        end

        hpc_reset_n  = (state_n == S_IDLE) || (state_n == S_CLEAR);
        hpc_enable_n = (state_n == S_RUN);
        hpc_freeze_n = (state_n == S_CAPTURE) || (state_n == S_DONE);
        busy_n       = (state_n == S_CLEAR) || (state_n == S_RUN) ||
                       (state_n == S_DRAIN) || (state_n == S_CAPTURE);
        done_n       = (state_n == S_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            len_q        <= '0;
            o_hpc_reset  <= 1'b1;
            o_hpc_enable <= 1'b0;
            o_hpc_freeze <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_aborted    <= 1'b0;
            o_fail       <= 1'b0;
            o_cycles_run <= '0;
            o_data_cap   <= '0;
            o_event_cap  <= '0;
        end else begin
            state_q      <= state_n;
            timer_q      <= timer_n;
            len_q        <= len_n;
            o_hpc_reset  <= hpc_reset_n;
            o_hpc_enable <= hpc_enable_n;
            o_hpc_freeze <= hpc_freeze_n;
            o_busy       <= busy_n;
            o_done       <= done_n;
            o_aborted    <= aborted_n;
            o_fail       <= fail_n;
            o_cycles_run <= cycles_n;
            o_data_cap   <= data_n;
            o_event_cap  <= event_n;
        end
    end

endmodule
